alu_arbiter: RTL
================

# alu_arbiter

Sequencer and arbiter that shares the single Gumnut ALU between two requesters: port A (core execute stage) and port B (coprocessor/debug unit). It accepts one operation at a time over a req/ack handshake and drives the ALU's operand, opcode, carry-in and shift-count inputs from registers. It captures the ALU result and flags, and keeps a separate carry/zero flag pair per requester so carry chains (ADDC/SUBC) from one port are never corrupted by the other.

## Interface
Parameters: none.

Ports (X = a or b; one set per requester):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- reqX_i  in  1  request; held high with operands stable until ackX_o
- opX_i  in  4  ALUOp code
- rsX_i  in  8  first operand
- op2X_i  in  8  second operand
- countX_i  in  3  shift count
- ackX_o  out  1  one-cycle completion pulse
- resX_o  out  8  result, valid while ackX_o is high, held afterwards
- carryX_o  out  1  requester's carry flag
- zeroX_o  out  1  requester's zero flag
- alu_rs_o, alu_op2_o  out  8  ALU operand drive
- alu_op_o  out  4  ALU opcode drive
- alu_carry_o  out  1  ALU carry-in drive
- alu_count_o  out  3  ALU shift-count drive
- alu_res_i  in  8  ALU result
- alu_carry_i  in  1  ALU carry out
- alu_zero_i  in  1  ALU zero out
- busy_o  out  1  high in ISSUE and DONE

## Operation
- Opcode encoding:
  - ADD 0000, ADDC 0001, SUB 0010, SUBC 0011
  - AND 0100, OR 0101, XOR 0110, MASK 0111
  - SHL 1000, SHR 1001, ROL 1010, ROR 1011
  - 11xx is passed through unchanged; the ALU yields res 0x00, carry 0, zero 1.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner, latch its op/rs/op2/count into the alu_*_o registers, drive alu_carry_o from the winner's carry flag, go to ISSUE.
- ISSUE: the ALU evaluates combinationally. At the edge, capture alu_res_i into the winner's resX_o and alu_carry_i/alu_zero_i into the winner's flags, then go to DONE.
- DONE: ackX_o of the winner is high for exactly this cycle. Go to IDLE unconditionally.
- The loser's request is held pending and is arbitrated again in the next IDLE. It is never dropped.
- Arbitration (default): round-robin.
  - A last_grant register records the last winner.
  - Both requesting: grant the one not equal to last_grant.
  - Single requester: granted regardless of last_grant.
  - last_grant updates on entering ISSUE.
- Flags update on every completed operation, including logic ops (carry 0) and 11xx ops.
- The other requester's flags and resX_o never change.

## Timing
- Request sampled high at edge N (IDLE) → ISSUE during cycle N+1 → ackX_o high during cycle N+2.
- Result and flags are visible from cycle N+2 and held until that requester's next completion.
- Throughput: one operation per 3 cycles. A requester must drop reqX_i at the edge ending its ack cycle, or the arbiter treats the request as a new one.
- Operand or request changes during ISSUE/DONE are ignored; the latched values are used.
- Reset values:
  - state IDLE, last_grant = B (so A wins the first tie)
  - all ack 0, busy_o 0, resX_o 0x00, carryX_o 0, zeroX_o 0
  - alu_*_o all zero
- Reset mid-operation (ISSUE or DONE): the operation is abandoned, no ack is issued, flags are not updated, all values return to reset values the cycle after rst_i is sampled.
- rst_i has priority over every other event, including a simultaneous request.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority; A always wins when both request (B can starve); last_grant is unused.
- Undefined: round-robin as above.
- The handshake, latency and flag behaviour are identical in both builds.

## Test plan
- A only, ADD rs=0x7F op2=0x01, req at edge 0: ackA high in cycle 2, resA=0x80, carryA=0, zeroA=0; ackB never high.
- A ADD 0xFF+0x01 → resA=0x00, carryA=1, zeroA=1. Then B ADDC 0x00+0x00 → resB=0x00 (B's carry is 0). Then A ADDC 0x00+0x00 → resA=0x01.
- A and B both hold requests continuously (re-asserted after each ack): grant order A,B,A,B, one ack every 3 cycles. With ALU_ARB_FIXED_PRIO_EN: A,A,A and B never acked.
- B AND 0xF0 & 0x3C → resB=0x30, carryB=0, zeroB=0; A's flags are unchanged.
- rst_i asserted during ISSUE of an A request: no ackA, carryA=0, resA=0x00, alu_op_o=0 next cycle. After reset release, a held reqA completes 3 cycles later.
- Opcode 1100 from A with rs=0x55: resA=0x00, carryA=0, zeroA=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one Gumnut ALU between requester A and requester B over req/ack handshakes,
// keeping per-requester result and carry/zero flags. ALU_ARB_FIXED_PRIO_EN selects fixed A priority.
module alu_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reqa_i,
    input  logic [3:0] opa_i,
    input  logic [7:0] rsa_i,
    input  logic [7:0] op2a_i,
    input  logic [2:0] counta_i,
    output logic       acka_o,
    output logic [7:0] resa_o,
    output logic       carrya_o,
    output logic       zeroa_o,
    input  logic       reqb_i,
    input  logic [3:0] opb_i,
    input  logic [7:0] rsb_i,
    input  logic [7:0] op2b_i,
    input  logic [2:0] countb_i,
    output logic       ackb_o,
    output logic [7:0] resb_o,
    output logic       carryb_o,
    output logic       zerob_o,
    output logic [7:0] alu_rs_o,
    output logic [7:0] alu_op2_o,
    output logic [3:0] alu_op_o,
    output logic       alu_carry_o,
    output logic [2:0] alu_count_o,
    input  logic [7:0] alu_res_i,
    input  logic       alu_carry_i,
    input  logic       alu_zero_i,
    output logic       busy_o
);

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 3;
    localparam logic        SEL_A = 1'b0;
    localparam logic        SEL_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_win;
    logic   w_any_req;
    logic   w_grant_b;

    assign w_any_req = reqa_i | reqb_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant_b = reqb_i & ~reqa_i;
`else
    logic r_last_grant;
    // On a tie, grant whoever did not win last time.
    assign w_grant_b = reqb_i & (~reqa_i | (r_last_grant == SEL_A));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_win       <= SEL_A;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= SEL_B;
`endif
            acka_o      <= 1'b0;
            ackb_o      <= 1'b0;
            resa_o      <= '0;
            resb_o      <= '0;
            carrya_o    <= 1'b0;
            zeroa_o     <= 1'b0;
            carryb_o    <= 1'b0;
            zerob_o     <= 1'b0;
            alu_rs_o    <= '0;
            alu_op2_o   <= '0;
            alu_op_o    <= '0;
            alu_carry_o <= 1'b0;
            alu_count_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win <= w_grant_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant_b;
`endif
                        alu_op_o    <= w_grant_b ? OW'(opb_i)    : OW'(opa_i);
                        alu_rs_o    <= w_grant_b ? DW'(rsb_i)    : DW'(rsa_i);
                        alu_op2_o   <= w_grant_b ? DW'(op2b_i)   : DW'(op2a_i);
                        alu_count_o <= w_grant_b ? CW'(countb_i) : CW'(counta_i);
                        // Carry-in comes from the winner's own flag so carry chains stay per port.
                        alu_carry_o <= w_grant_b ? carryb_o : carrya_o;
                        busy_o      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_win == SEL_B) begin
                        resb_o   <= alu_res_i;
                        carryb_o <= alu_carry_i;
                        zerob_o  <= alu_zero_i;
                        ackb_o   <= 1'b1;
                    end else begin
                        resa_o   <= alu_res_i;
                        carrya_o <= alu_carry_i;
                        zeroa_o  <= alu_zero_i;
                        acka_o   <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    acka_o  <= 1'b0;
                    ackb_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    acka_o  <= 1'b0;
                    ackb_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
